// File: rtl/softmax_uart_pkg.sv
// Shared constants, state encodings and helpers
// for the UART softmax frame bridge.
package softmax_uart_pkg;

   localparam logic [7:0] SYNC_REQ = 8'hA5;
   localparam logic [7:0] SYNC_RSP = 8'h5A;
   localparam logic [7:0] SYNC_ERR = 8'hEE;
   localparam logic [7:0] ERR_LEN  = 8'h01;
   localparam logic [7:0] ERR_CK   = 8'h02;

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN,
      S_DATA,
      S_CHK,
      S_ISSUE,
      S_WAITY,
      S_TX,
      S_TXERR
   } state_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_ISSUE,
      F_WAIT
   } ftx_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_softmax_bridge_if.sv
// Valid/ready bundle between the bridge (master)
// and the softmax core (slave).
interface uart_softmax_bridge_if #(
   parameter int N = 64,
   parameter int W = 16
) ();

   logic [N*W-1:0] sm_x;
   logic           sm_x_valid;
   logic           sm_ready;
   logic [N*W-1:0] sm_y;
   logic           sm_y_valid;
   logic           sm_y_ready;

   modport master (
      output sm_x, sm_x_valid, sm_y_ready,
      input  sm_ready, sm_y, sm_y_valid
   );

   modport slave (
      input  sm_x, sm_x_valid, sm_y_ready,
      output sm_ready, sm_y, sm_y_valid
   );

endinterface

// File: rtl/uart_frame_tx.sv
// Byte sequencer: walks a byte-indexed source through
// the uart_tx start/done handshake, appending an XOR byte.
module uart_frame_tx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] nbytes,
   input  logic        with_ck,
   output logic [15:0] rd_idx,
   input  logic [7:0]  rd_data,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   input  logic        tx_active,
   input  logic        tx_done,
   output logic        done
);
   import softmax_uart_pkg::*;

   ftx_state_t  st;
   logic [7:0]  ck;
   logic [15:0] last;
   logic [7:0]  byte_sel;

   // Checksum byte sits just past the sourced bytes.
   assign last     = with_ck ? nbytes : nbytes - 16'd1;
   assign byte_sel = (with_ck && rd_idx == nbytes) ? ck : rd_data;

   // One byte outstanding at a time; XOR covers bytes 1..nbytes-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= F_IDLE;
         rd_idx   <= '0;
         ck       <= '0;
         tx_start <= 1'b0;
         tx_byte  <= '0;
         done     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         unique case (st)
            F_IDLE: begin
               if (start) begin
                  ck <= '0;
                  if (!tx_active) begin
                     tx_start <= 1'b1;
                     tx_byte  <= rd_data;
                     st       <= F_WAIT;
                  end else begin
                     st <= F_ISSUE;
                  end
               end
            end
            F_ISSUE: begin
               if (!tx_active) begin
                  tx_start <= 1'b1;
                  tx_byte  <= byte_sel;
                  if (rd_idx != 16'd0 && rd_idx != nbytes)
                     ck <= ck ^ rd_data;
                  st <= F_WAIT;
               end
            end
            F_WAIT: begin
               if (tx_done) begin
                  if (rd_idx == last) begin
                     done   <= 1'b1;
                     rd_idx <= '0;
                     st     <= F_IDLE;
                  end else begin
                     rd_idx <= rd_idx + 16'd1;
                     st     <= F_ISSUE;
                  end
               end
            end
            default: st <= F_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_softmax_bridge.sv
// UART request parser, softmax handshake and
// response/error framing around a softmax core.
module uart_softmax_bridge #(
   parameter int             N           = 64,
   parameter int             W           = 16,
   parameter logic [W-1:0]   PAD         = 16'hFC00,
   parameter int             TIMEOUT_CYC = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  tx_start,
   output logic [7:0]            tx_byte,
   input  logic                  tx_active,
   input  logic                  tx_done,
   uart_softmax_bridge_if.master sm,
   output logic [7:0]            err_count
);
   import softmax_uart_pkg::*;

   localparam int          XW      = N * W;
   localparam int          BPE     = W / 8;
   localparam logic [7:0]  NL      = 8'(N);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   state_t        state;
   logic [7:0]    len;
   logic [7:0]    ck;
   logic [7:0]    code;
   logic [15:0]   bidx;
   logic [15:0]   nb;
   logic [31:0]   tcnt;
   logic [XW-1:0] res;
   logic [XW-1:0] ins;
   logic [XW-1:0] msk;
   logic          go;
   logic          fdone;
   logic          rx_phase;
   logic          to_hit;
   logic          is_err;
   logic [15:0]   fr_len;
   logic [15:0]   rd_idx;
   logic [7:0]    rd_data;

   assign nb       = 16'(len) * 16'(BPE);
   assign rx_phase = state inside {S_LEN, S_DATA, S_CHK};
   assign to_hit   = rx_phase && !rx_valid && tcnt == TO_LAST;
   assign msk      = XW'(8'hFF) << {bidx, 3'b000};
   assign ins      = XW'(rx_byte) << {bidx, 3'b000};
   assign is_err   = (state == S_TXERR);
   assign fr_len   = is_err ? 16'd2 : nb + 16'd2;

   // Parser / handshake FSM with inter-byte timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_SYNC;
         len           <= '0;
         ck            <= '0;
         code          <= '0;
         bidx          <= '0;
         tcnt          <= '0;
         res           <= '0;
         go            <= 1'b0;
         err_count     <= '0;
         sm.sm_x       <= '0;
         sm.sm_x_valid <= 1'b0;
         sm.sm_y_ready <= 1'b0;
      end else begin
         go <= 1'b0;
         if (rx_phase && !rx_valid && !to_hit)
            tcnt <= tcnt + 32'd1;
         else
            tcnt <= '0;
         if (to_hit) begin
            state     <= S_SYNC;
            err_count <= sat_inc(err_count);
         end else begin
            unique case (state)
               S_SYNC: begin
                  if (rx_valid && rx_byte == SYNC_REQ)
                     state <= S_LEN;
               end
               S_LEN: begin
                  if (rx_valid) begin
                     if (rx_byte != 8'd0 && rx_byte <= NL) begin
                        len     <= rx_byte;
                        ck      <= rx_byte;
                        bidx    <= '0;
                        sm.sm_x <= {N{PAD}};
                        state   <= S_DATA;
                     end else begin
                        code      <= ERR_LEN;
                        go        <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= S_TXERR;
                     end
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     sm.sm_x <= (sm.sm_x & ~msk) | ins;
                     ck      <= ck ^ rx_byte;
                     bidx    <= bidx + 16'd1;
                     if (bidx == nb - 16'd1)
                        state <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (rx_valid) begin
                     if (rx_byte == ck) begin
                        sm.sm_x_valid <= 1'b1;
                        state         <= S_ISSUE;
                     end else begin
                        code      <= ERR_CK;
                        go        <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= S_TXERR;
                     end
                  end
               end
               S_ISSUE: begin
                  if (sm.sm_ready) begin
                     sm.sm_x_valid <= 1'b0;
                     sm.sm_y_ready <= 1'b1;
                     state         <= S_WAITY;
                  end
               end
               S_WAITY: begin
                  if (sm.sm_y_valid) begin
                     res           <= sm.sm_y;
                     sm.sm_y_ready <= 1'b0;
                     go            <= 1'b1;
                     state         <= S_TX;
                  end
               end
               S_TX, S_TXERR: begin
                  if (fdone)
                     state <= S_SYNC;
               end
               default: state <= S_SYNC;
            endcase
         end
      end
   end

   // Byte source for the sequencer: header, then result bytes.
   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         (rd_idx == 16'd0): rd_data = is_err ? SYNC_ERR : SYNC_RSP;
         (rd_idx == 16'd1): rd_data = is_err ? code : len;
         default:           rd_data = 8'(res >> {rd_idx - 16'd2, 3'b000});
      endcase
   end

   uart_frame_tx u_ftx (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (go),
      .nbytes    (fr_len),
      .with_ck   (!is_err),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .tx_active (tx_active),
      .tx_done   (tx_done),
      .done      (fdone)
   );

endmodule

// File: tb/tb_uart_softmax_bridge.sv
// Randomised bench for uart_softmax_bridge with
// UART and softmax behavioural models.
module tb_uart_softmax_bridge;

   localparam int          N   = 64;
   localparam int          W   = 16;
   localparam int          BPE = W / 8;
   localparam int          TO  = 300;
   localparam logic [15:0] PAD = 16'hFC00;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_active = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] err_count;

   uart_softmax_bridge_if #(.N(N), .W(W)) sm ();

   uart_softmax_bridge #(
      .N(N), .W(W), .PAD(PAD), .TIMEOUT_CYC(TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .tx_active (tx_active),
      .tx_done   (tx_done),
      .sm        (sm),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   bit             hold_ready = 1'b0;
   bit             yfix = 1'b0;
   bit             long_tx = 1'b0;
   logic [N*W-1:0] x_cap = '0;
   int             n_hs = 0;
   logic [7:0]     txq[$];
   int             exp_err = 0;

   function automatic logic [15:0] yfun(input logic [15:0] x,
                                        input int i);
      if (yfix) return 16'h3800;
      return (x ^ 16'h5A5A) + 16'(i);
   endfunction

   // Softmax core model: random ready, random output latency.
   initial begin
      int             ph;
      int             cnt;
      bit             hs_next;
      bit             prev_v;
      logic [N*W-1:0] prev_x;
      ph = 0; cnt = 0; hs_next = 0; prev_v = 0; prev_x = '0;
      sm.sm_ready = 1'b0;
      sm.sm_y_valid = 1'b0;
      sm.sm_y = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ph = 0; hs_next = 0; prev_v = 0;
            sm.sm_y_valid = 1'b0;
            sm.sm_ready = 1'b0;
            continue;
         end
         if (prev_v && sm.sm_x_valid)
            chk("x_stable", 64'(sm.sm_x == prev_x), 1);
         prev_v = sm.sm_x_valid;
         prev_x = sm.sm_x;
         if (hs_next) begin
            sm.sm_y_valid = 1'b0;
            hs_next = 0;
            ph = 0;
         end
         if (ph == 1) begin
            cnt--;
            if (cnt == 0) begin
               for (int i = 0; i < N; i++)
                  sm.sm_y[i*W +: W] = yfun(x_cap[i*W +: W], i);
               sm.sm_y_valid = 1'b1;
               ph = 2;
            end
         end
         if (ph == 2 && sm.sm_y_ready) hs_next = 1;
         if (ph == 0) begin
            sm.sm_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
            if (sm.sm_x_valid && sm.sm_ready) begin
               x_cap = sm.sm_x;
               n_hs++;
               ph = 1;
               cnt = $urandom_range(1, 4);
            end
         end else begin
            sm.sm_ready = 1'b0;
         end
      end
   end

   // uart_tx model: records bytes, random busy time, done pulse.
   initial begin
      bit         busy;
      int         cnt;
      logic [7:0] cur;
      busy = 0; cnt = 0; cur = 8'd0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (!rst_n) begin
            busy = 0;
            tx_active = 1'b0;
            continue;
         end
         if (tx_start) begin
            chk("tx_pace", 64'(busy), 0);
            txq.push_back(tx_byte);
            cur = tx_byte;
            busy = 1;
            tx_active = 1'b1;
            cnt = long_tx ? $urandom_range(5, 25) : $urandom_range(1, 4);
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               chk("tx_hold", tx_byte, cur);
               tx_done = 1'b1;
               tx_active = 1'b0;
               busy = 0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   function automatic bq_t mk_frame(input int L, input bit bad);
      bq_t        q;
      logic [7:0] ck;
      logic [7:0] b;
      q.push_back(8'hA5);
      q.push_back(8'(L));
      if (L >= 1 && L <= N) begin
         ck = 8'(L);
         for (int i = 0; i < L * BPE; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            ck ^= b;
         end
         q.push_back(bad ? ck + 8'd1 : ck);
      end
      return q;
   endfunction

   task automatic bump_err();
      if (exp_err < 255) exp_err++;
   endtask

   // Model the frame, drive it, and compare everything observable.
   task automatic run_frame(input bq_t req);
      bq_t         rsp;
      bit          ok;
      int          L;
      int          hs0;
      int          t;
      logic [7:0]  ck;
      logic [15:0] y;
      logic [15:0] xl [N];
      ok = 0;
      L = int'(req[1]);
      if (L == 0 || L > N) begin
         rsp.push_back(8'hEE);
         rsp.push_back(8'h01);
         bump_err();
      end else begin
         ck = 8'(L);
         for (int i = 2; i < req.size() - 1; i++) ck ^= req[i];
         if (ck != req[req.size()-1]) begin
            rsp.push_back(8'hEE);
            rsp.push_back(8'h02);
            bump_err();
         end else begin
            ok = 1;
            for (int i = 0; i < N; i++) begin
               xl[i] = PAD;
               if (i < L)
                  for (int j = 0; j < BPE; j++)
                     xl[i][8*j +: 8] = req[2 + i*BPE + j];
            end
            rsp.push_back(8'h5A);
            rsp.push_back(8'(L));
            ck = 8'(L);
            for (int i = 0; i < L; i++) begin
               y = yfun(xl[i], i);
               for (int j = 0; j < BPE; j++) begin
                  rsp.push_back(y[8*j +: 8]);
                  ck ^= y[8*j +: 8];
               end
            end
            rsp.push_back(ck);
         end
      end
      txq.delete();
      hs0 = n_hs;
      for (int i = 0; i < req.size(); i++)
         send_byte(req[i], (i == req.size() - 1) ? 0 : $urandom_range(0, 1));
      chk("x_valid_lat", 64'(sm.sm_x_valid), 64'(ok));
      t = 0;
      while (txq.size() < rsp.size() && t < 20000) begin
         @(negedge clk);
         t++;
      end
      repeat (40) @(negedge clk);
      chk("rsp_len", txq.size(), rsp.size());
      for (int i = 0; i < rsp.size() && i < txq.size(); i++)
         chk("rsp_byte", txq[i], rsp[i]);
      chk("handshakes", 64'(n_hs - hs0), 64'(ok));
      if (ok)
         for (int i = 0; i < N; i++)
            chk("x_lane", x_cap[i*W +: W], xl[i]);
      chk("err_count", err_count, 64'(exp_err));
   endtask

   task automatic chk_rst();
      chk("rst_tx_start", 64'(tx_start), 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_sm_x", 64'(sm.sm_x == '0), 1);
      chk("rst_x_valid", 64'(sm.sm_x_valid), 0);
      chk("rst_y_ready", 64'(sm.sm_y_ready), 0);
      chk("rst_err", err_count, 0);
   endtask

   // Directed cases, boundaries, random frames, reset mid-TX.
   initial begin
      bq_t        q;
      int         t;
      int         r;
      logic [7:0] junk;
      repeat (3) @(negedge clk);
      chk_rst();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      yfix = 1;
      q = {8'hA5, 8'h02, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'h02};
      run_frame(q);
      yfix = 0;

      q = {8'hA5, 8'h41};
      run_frame(q);
      run_frame(mk_frame(4, 0));

      run_frame(mk_frame(7, 1));

      txq.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      repeat (TO + 30) @(negedge clk);
      bump_err();
      chk("to_no_tx", txq.size(), 0);
      chk("to_err", err_count, 64'(exp_err));
      run_frame(mk_frame(2, 0));

      run_frame(mk_frame(1, 0));
      run_frame(mk_frame(N, 0));
      q = {8'hA5, 8'h00};
      run_frame(q);
      q = {8'hA5, 8'(N + 1)};
      run_frame(q);

      hold_ready = 1;
      long_tx = 1;
      fork
         run_frame(mk_frame(3, 0));
         begin
            t = 0;
            while (!sm.sm_x_valid && t < 2000) begin
               @(negedge clk);
               t++;
            end
            chk("hold_start", 64'(sm.sm_x_valid), 1);
            repeat (50) begin
               @(negedge clk);
               chk("hold_valid", 64'(sm.sm_x_valid), 1);
            end
            hold_ready = 0;
         end
      join
      long_tx = 0;

      for (int k = 0; k < 12; k++) begin
         junk = 8'($urandom);
         if (junk == 8'hA5) junk = 8'h00;
         send_byte(junk, 0);
         r = $urandom_range(0, 7);
         if (r == 0)      q = {8'hA5, 8'h00};
         else if (r == 1) q = {8'hA5, 8'($urandom_range(N + 1, 255))};
         else if (r == 2) q = mk_frame($urandom_range(1, N), 1);
         else             q = mk_frame($urandom_range(1, N), 0);
         run_frame(q);
      end

      q = mk_frame(8, 0);
      txq.delete();
      for (int i = 0; i < q.size(); i++) send_byte(q[i], 0);
      t = 0;
      while (txq.size() < 3 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid_tx", 64'(txq.size() >= 3), 1);
      #2 rst_n = 1'b0;
      #1 chk_rst();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_err = 0;
      repeat (2) @(negedge clk);
      txq.delete();
      run_frame(mk_frame(5, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
